hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Detects load-use and RAW hazards,
// flushes on taken branches, freezes the whole pipeline while data memory is
// busy, and selects EX operand forwarding sources.
// Build option: define HAZARD_FWD_EN to enable EX-stage forwarding; when it is
// not defined, fwd_a/fwd_b stay 00 and ALU RAW hazards stall for one cycle.
module hazard_ctrl #(
  parameter int REG_AW = 4,
  parameter int LU_CYC = 1,
  parameter int BR_PEN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wr,
  input  logic              br_taken,
  input  logic              dmem_busy,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, FREEZE} state_t;

  localparam logic [1:0] LU_INIT = 2'(LU_CYC - 1);
  localparam logic [1:0] BR_INIT = 2'(BR_PEN - 1);

  state_t     state_q, state_d, saved_q, saved_d, eff_state;
  logic [1:0] cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt;
  logic       lu_haz, raw_haz;
  logic       pc_stall_c, ifid_stall_c, idex_bubble_c;
  logic       ifid_flush_c, idex_flush_c, exmem_stall_c;

  // A producer matches a consumer only for a nonzero register that is both
  // written and actually read.
  function automatic logic reg_hit(input logic [REG_AW-1:0] rd, input logic wr,
                                   input logic [REG_AW-1:0] src, input logic used);
    return wr && used && (rd != '0) && (rd == src);
  endfunction

  assign lu_haz = ex_memread && (reg_hit(ex_rd, ex_wr, id_rs, id_rs_used) ||
                                 reg_hit(ex_rd, ex_wr, id_rt, id_rt_used));

`ifdef HAZARD_FWD_EN
  assign raw_haz = 1'b0;
`else
  assign raw_haz = reg_hit(ex_rd, ex_wr, id_rs, id_rs_used)   ||
                   reg_hit(ex_rd, ex_wr, id_rt, id_rt_used)   ||
                   reg_hit(mem_rd, mem_wr, id_rs, id_rs_used) ||
                   reg_hit(mem_rd, mem_wr, id_rt, id_rt_used);
`endif

  // Next-state and control outputs; a freeze that ends resumes the saved state
  // in the same cycle, so the saved state drives the decode then.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    idex_bubble_c = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_stall_c = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_d       = saved_q;
    saved_cnt_d   = saved_cnt_q;
    eff_state     = state_q;
    eff_cnt       = cnt_q;
    if (state_q == FREEZE && !dmem_busy) begin
      eff_state = saved_q;
      eff_cnt   = saved_cnt_q;
    end

    if (dmem_busy) begin
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      exmem_stall_c = 1'b1;
      state_d       = FREEZE;
      if (state_q != FREEZE) begin
        saved_d     = state_q;
        saved_cnt_d = cnt_q;
      end
    end else begin
      case (eff_state)
        RUN, LU_STALL: begin
          if (br_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            state_d      = (BR_PEN > 1) ? FLUSH : RUN;
            cnt_d        = (BR_PEN > 1) ? BR_INIT : 2'd0;
          end else if (eff_state == LU_STALL) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_d       = (eff_cnt <= 2'd1) ? RUN : LU_STALL;
            cnt_d         = (eff_cnt <= 2'd1) ? 2'd0 : eff_cnt - 2'd1;
          end else if (lu_haz) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_d       = (LU_CYC > 1) ? LU_STALL : RUN;
            cnt_d         = (LU_CYC > 1) ? LU_INIT : 2'd0;
          end else if (raw_haz) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_d       = RUN;
            cnt_d         = 2'd0;
          end else begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end
        end
        FLUSH: begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          state_d      = (eff_cnt <= 2'd1) ? RUN : FLUSH;
          cnt_d        = (eff_cnt <= 2'd1) ? 2'd0 : eff_cnt - 2'd1;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // State, counter and freeze save registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      saved_q     <= RUN;
      saved_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      saved_q     <= saved_d;
      saved_cnt_q <= saved_cnt_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (pc_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign pc_stall    = pc_stall_c    & ~rst;
  assign ifid_stall  = ifid_stall_c  & ~rst;
  assign idex_bubble = idex_bubble_c & ~rst;
  assign ifid_flush  = ifid_flush_c  & ~rst;
  assign idex_flush  = idex_flush_c  & ~rst;
  assign exmem_stall = exmem_stall_c & ~rst;

`ifdef HAZARD_FWD_EN
  logic mem_a, mem_b, wb_a, wb_b;
  assign mem_a = reg_hit(mem_rd, mem_wr, ex_rs, 1'b1);
  assign mem_b = reg_hit(mem_rd, mem_wr, ex_rt, 1'b1);
  assign wb_a  = reg_hit(wb_rd, wb_wr, ex_rs, 1'b1);
  assign wb_b  = reg_hit(wb_rd, wb_wr, ex_rt, 1'b1);
  // The younger MEM result wins over the older WB result.
  assign fwd_a = rst ? 2'b00 : mem_a ? 2'b01 : wb_a ? 2'b10 : 2'b00;
  assign fwd_b = rst ? 2'b00 : mem_b ? 2'b01 : wb_b ? 2'b10 : 2'b00;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_rs, ex_rt, wb_rd, wb_wr};
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl instances (LU_CYC=1/BR_PEN=1/CNT_W=16 and
// LU_CYC=3/BR_PEN=2/CNT_W=4) share one stimulus stream; a pause/countdown
// model predicts every output on every cycle, plus directed literal checks.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_rs_used, id_rt_used, ex_wr, ex_memread, mem_wr, wb_wr;
  logic       br_taken, dmem_busy;

  logic        a_pc, a_ifs, a_bub, a_iff, a_idf, a_exm;
  logic [1:0]  a_fa, a_fb;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifs, b_bub, b_iff, b_idf, b_exm;
  logic [1:0]  b_fa, b_fb;
  logic [3:0]  b_cnt;

  logic [1:0][9:0]  act_vec;
  logic [1:0][15:0] act_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: remaining load-use cycles, remaining flush cycles, stall count.
  int lu_left [2] = '{0, 0};
  int fl_left [2] = '{0, 0};
  int m_cnt   [2] = '{0, 0};
  int lu_p    [2] = '{1, 3};
  int br_p    [2] = '{1, 2};
  int m_max   [2] = '{65535, 15};

  hazard_ctrl #(.REG_AW(4), .LU_CYC(1), .BR_PEN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_stall(a_pc), .ifid_stall(a_ifs), .idex_bubble(a_bub),
    .ifid_flush(a_iff), .idex_flush(a_idf), .exmem_stall(a_exm),
    .fwd_a(a_fa), .fwd_b(a_fb), .stall_cnt(a_cnt)
  );

  hazard_ctrl #(.REG_AW(4), .LU_CYC(3), .BR_PEN(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_stall(b_pc), .ifid_stall(b_ifs), .idex_bubble(b_bub),
    .ifid_flush(b_iff), .idex_flush(b_idf), .exmem_stall(b_exm),
    .fwd_a(b_fa), .fwd_b(b_fb), .stall_cnt(b_cnt)
  );

  assign act_vec[0] = {a_pc, a_ifs, a_bub, a_iff, a_idf, a_exm, a_fa, a_fb};
  assign act_vec[1] = {b_pc, b_ifs, b_bub, b_iff, b_idf, b_exm, b_fa, b_fb};
  assign act_cnt[0] = a_cnt;
  assign act_cnt[1] = {12'd0, b_cnt};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [3:0] rd, input logic wr,
                               input logic [3:0] src, input logic used);
    return wr && used && (rd != 4'd0) && (rd == src);
  endfunction

  // Compare process: predicts all outputs each cycle, then advances the model.
  // dmem_busy pauses everything; a pending flush runs before anything else;
  // a branch cancels a pending load-use stall; load-use beats a plain RAW stall.
  initial begin
    logic       lu, raw;
    logic [1:0] fa, fb;
    logic [5:0] ctl;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int m = 0; m < 2; m++) begin
          check($sformatf("reset_vec%0d", m), 32'(act_vec[m]), 32'd0);
          check($sformatf("reset_cnt%0d", m), 32'(act_cnt[m]), 32'd0);
          lu_left[m] = 0;
          fl_left[m] = 0;
          m_cnt[m]   = 0;
        end
      end else begin
        lu = ex_memread && (hit(ex_rd, ex_wr, id_rs, id_rs_used) ||
                            hit(ex_rd, ex_wr, id_rt, id_rt_used));
`ifdef HAZARD_FWD_EN
        raw = 1'b0;
        fa  = hit(mem_rd, mem_wr, ex_rs, 1'b1) ? 2'b01 : hit(wb_rd, wb_wr, ex_rs, 1'b1) ? 2'b10 : 2'b00;
        fb  = hit(mem_rd, mem_wr, ex_rt, 1'b1) ? 2'b01 : hit(wb_rd, wb_wr, ex_rt, 1'b1) ? 2'b10 : 2'b00;
`else
        raw = hit(ex_rd, ex_wr, id_rs, id_rs_used) || hit(ex_rd, ex_wr, id_rt, id_rt_used) ||
              hit(mem_rd, mem_wr, id_rs, id_rs_used) || hit(mem_rd, mem_wr, id_rt, id_rt_used);
        fa  = 2'b00;
        fb  = 2'b00;
`endif
        for (int m = 0; m < 2; m++) begin
          ctl = 6'b000000;
          if (dmem_busy) begin
            ctl = 6'b110001;
          end else if (fl_left[m] > 0) begin
            ctl = 6'b000110;
            fl_left[m]--;
          end else if (br_taken) begin
            ctl = 6'b000110;
            fl_left[m] = br_p[m] - 1;
            lu_left[m] = 0;
          end else if (lu_left[m] > 0) begin
            ctl = 6'b111000;
            lu_left[m]--;
          end else if (lu) begin
            ctl = 6'b111000;
            lu_left[m] = lu_p[m] - 1;
          end else if (raw) begin
            ctl = 6'b111000;
          end
          check($sformatf("cyc_vec%0d", m), 32'(act_vec[m]), 32'({ctl, fa, fb}));
          check($sformatf("cyc_cnt%0d", m), 32'(act_cnt[m]), 32'(m_cnt[m]));
          if (ctl[5] && m_cnt[m] < m_max[m]) m_cnt[m]++;
        end
      end
    end
  end

  task automatic idle_inputs();
    id_rs = 4'd0; id_rt = 4'd0; ex_rs = 4'd0; ex_rt = 4'd0; ex_rd = 4'd0;
    mem_rd = 4'd0; wb_rd = 4'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_wr = 1'b0; ex_memread = 1'b0;
    mem_wr = 1'b0; wb_wr = 1'b0; br_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    idle_inputs();
    repeat (n) next_cyc();
  endtask

  task automatic set_load_use();
    ex_memread = 1'b1; ex_wr = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    next_cyc();

    // LW r3 in EX, ID reads r3: one stall cycle on the LU_CYC=1 instance.
    set_load_use();
    settle();
    check("lu_stall_a", 32'({a_pc, a_ifs, a_bub}), 32'h7);
    check("lu_cnt_start_a", 32'(a_cnt), 32'd0);
    next_cyc();
    idle_inputs();
    settle();
    check("lu_release_a", 32'({a_pc, a_ifs, a_bub}), 32'h0);
    check("lu_cnt_a", 32'(a_cnt), 32'd1);
    gap(4);

    // Same hazard through register 0: no stall.
    set_load_use();
    ex_rd = 4'd0; id_rs = 4'd0;
    settle();
    check("r0_nostall_a", 32'(a_pc), 32'd0);
    check("r0_nostall_b", 32'(b_pc), 32'd0);
    next_cyc();
    gap(2);

    // Branch with coincident load-use on BR_PEN=2: two flush cycles, no bubble.
    set_load_use();
    br_taken = 1'b1;
    settle();
    check("br_lu_b", 32'({b_pc, b_ifs, b_bub, b_iff, b_idf, b_exm}), 32'h06);
    next_cyc();
    idle_inputs();
    settle();
    check("br_hold_b", 32'({b_pc, b_ifs, b_bub, b_iff, b_idf, b_exm}), 32'h06);
    check("br_done_a", 32'({a_iff, a_idf}), 32'h0);
    next_cyc();
    settle();
    check("br_end_b", 32'({b_iff, b_idf}), 32'h0);
    check("br_cnt_b", 32'(b_cnt), 32'd3);
    gap(2);

    // LU_CYC=3 stall interrupted by a 4-cycle freeze from the 2nd stall cycle.
    set_load_use();
    settle();
    check("frz_lu1_b", 32'({b_pc, b_ifs, b_bub, b_iff, b_idf, b_exm}), 32'h38);
    next_cyc();
    idle_inputs();
    dmem_busy = 1'b1;
    repeat (4) begin
      settle();
      check("frz_hold_b", 32'({b_pc, b_ifs, b_bub, b_iff, b_idf, b_exm}), 32'h31);
      next_cyc();
    end
    dmem_busy = 1'b0;
    repeat (2) begin
      settle();
      check("frz_resume_b", 32'({b_pc, b_ifs, b_bub, b_iff, b_idf, b_exm}), 32'h38);
      next_cyc();
    end
    settle();
    check("frz_end_b", 32'({b_pc, b_ifs, b_bub, b_iff, b_idf, b_exm}), 32'h00);
    check("frz_cnt_b", 32'(b_cnt), 32'd10);
    next_cyc();
    gap(2);

    // r5 produced in both MEM and WB, consumed in EX (and in ID).
    mem_rd = 4'd5; wb_rd = 4'd5; mem_wr = 1'b1; wb_wr = 1'b1;
    ex_rs = 4'd5; id_rs = 4'd5; id_rs_used = 1'b1;
    settle();
`ifdef HAZARD_FWD_EN
    check("fwd_mem_a", 32'(a_fa), 32'h1);
    check("fwd_nostall_a", 32'(a_pc), 32'd0);
    next_cyc();
    mem_wr = 1'b0;
    settle();
    check("fwd_wb_a", 32'(a_fa), 32'h2);
`else
    check("nofwd_sel_a", 32'(a_fa), 32'h0);
    check("nofwd_stall_a", 32'(a_pc), 32'd1);
    next_cyc();
    idle_inputs();
    settle();
    check("nofwd_release_a", 32'(a_pc), 32'd0);
`endif
    next_cyc();
    gap(2);

    // Asynchronous reset in the middle of a BR_PEN=2 flush.
    br_taken = 1'b1;
    next_cyc();
    idle_inputs();
    settle();
    check("pre_rst_flush_b", 32'({b_iff, b_idf}), 32'h3);
    #1 rst = 1'b1;
    #1;
    check("async_rst_vec_a", 32'(act_vec[0]), 32'd0);
    check("async_rst_vec_b", 32'(act_vec[1]), 32'd0);
    check("async_rst_cnt_b", 32'(act_cnt[1]), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    next_cyc();

    // Randomized traffic over a small register range to make matches common.
    for (int c = 0; c < 3000; c++) begin
      id_rs      = 4'($urandom_range(0, 3));
      id_rt      = 4'($urandom_range(0, 3));
      ex_rs      = 4'($urandom_range(0, 3));
      ex_rt      = 4'($urandom_range(0, 3));
      ex_rd      = 4'($urandom_range(0, 3));
      mem_rd     = 4'($urandom_range(0, 3));
      wb_rd      = 4'($urandom_range(0, 3));
      id_rs_used = 1'($urandom_range(0, 1));
      id_rt_used = 1'($urandom_range(0, 1));
      ex_wr      = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      mem_wr     = 1'($urandom_range(0, 1));
      wb_wr      = 1'($urandom_range(0, 1));
      br_taken   = ($urandom_range(0, 9) == 0);
      if (dmem_busy) dmem_busy = ($urandom_range(0, 9) < 6);
      else           dmem_busy = ($urandom_range(0, 19) == 0);
      next_cyc();
    end
    gap(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
